// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Holds the FSM state encoding, parity modes and legal ranges.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_BITS  = 5;
    localparam int MAX_BITS_LIM = 9;
    localparam int MIN_OVS   = 8;
    localparam int MAX_OVS   = 32;
    localparam int MIN_SYNC  = 2;

    // Saturate a requested word length into MIN_BITS..maxb
    function automatic logic [3:0] clamp_bits(
        input logic [3:0] n,
        input logic [3:0] maxb
    );
        if (n < 4'(MIN_BITS)) return 4'(MIN_BITS);
        if (n > maxb)         return maxb;
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Rx line synchroniser with low-level detect.
// Reset fills the chain with the idle level (1).
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic rx_i,
    output logic rx_o,
    output logic rx_low_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw line through the flop chain
    always_ff @(posedge Clk) begin
        if (!Rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    assign rx_o     = sync_q[SYNC_STAGES-1];
    assign rx_low_o = ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime word length, parity
// and stop-bit selection and a valid/ready output holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int MAX_BITS    = 9,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                RxEn,
    input  logic                Rx,
    input  logic                Tick,
    input  logic [3:0]          NBits,
    input  logic [1:0]          ParMode,
    input  logic                Stop2,
    output logic [MAX_BITS-1:0] RxData,
    output logic                RxValid,
    input  logic                RxReady,
    output logic                ParityErr,
    output logic                FrameErr,
    output logic                Overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);

    logic rx_s, rx_low;

    rx_state_e state_q, state_d;
    logic [CW-1:0]       tcnt_q, tcnt_d;
    logic [3:0]          bcnt_q, bcnt_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic                pacc_q, pacc_d;
    logic                facc_q, facc_d;
    logic [3:0]          nbits_q, nbits_d;
    logic [1:0]          pmode_q, pmode_d;
    logic                stop2_q, stop2_d;
    logic [MAX_BITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                done, done_ferr;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .rx_i    (Rx),
        .rx_o    (rx_s),
        .rx_low_o(rx_low)
    );

    // State, frame and output holding registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pacc_q  <= 1'b0;
            facc_q  <= 1'b0;
            nbits_q <= 4'(MIN_BITS);
            pmode_q <= PAR_NONE;
            stop2_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pacc_q  <= pacc_d;
            facc_q  <= facc_d;
            nbits_q <= nbits_d;
            pmode_q <= pmode_d;
            stop2_q <= stop2_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame sequencing: tick/bit counting, sampling and completion
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pacc_d    = pacc_q;
        facc_d    = facc_q;
        nbits_d   = nbits_q;
        pmode_d   = pmode_q;
        stop2_d   = stop2_q;
        done      = 1'b0;
        done_ferr = facc_q | ~rx_s;
        unique case (state_q)
            ST_IDLE: begin
                if (Tick && RxEn && rx_low) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    shift_d = '0;
                    par_d   = 1'b0;
                    pacc_d  = 1'b0;
                    facc_d  = 1'b0;
                    nbits_d = clamp_bits(NBits, 4'(MAX_BITS));
                    pmode_d = ParMode;
                    stop2_d = Stop2;
                end
            end
            ST_START: begin
                if (Tick) begin
                    if (tcnt_q == HALF) begin
                        tcnt_d  = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (Tick) begin
                    if (tcnt_q == FULL) begin
                        tcnt_d = '0;
                        par_d  = par_q ^ rx_s;
                        for (int i = 0; i < MAX_BITS; i++) begin
                            if (bcnt_q == 4'(i)) shift_d[i] = rx_s;
                        end
                        if (bcnt_q == nbits_q - 4'd1) begin
                            bcnt_d  = '0;
                            state_d = (pmode_q == PAR_EVEN ||
                                       pmode_q == PAR_ODD) ?
                                      ST_PARITY : ST_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 4'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (Tick) begin
                    if (tcnt_q == FULL) begin
                        tcnt_d  = '0;
                        pacc_d  = par_q ^ rx_s ^ (pmode_q == PAR_ODD);
                        state_d = ST_STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (Tick) begin
                    if (tcnt_q == FULL) begin
                        tcnt_d = '0;
                        facc_d = done_ferr;
                        if (stop2_q && bcnt_q == 4'd0) begin
                            bcnt_d = 4'd1;
                        end else begin
                            done    = 1'b1;
                            state_d = done_ferr ? ST_WAIT_HIGH : ST_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!RxEn && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            done    = 1'b0;
        end
    end

    // Output holding register with valid/ready and overrun
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        if (done && (!valid_q || RxReady)) begin
            data_d  = shift_q;
            perr_d  = pacc_q;
            ferr_d  = done_ferr;
            valid_d = 1'b1;
        end else begin
            if (done)               ovr_d   = 1'b1;
            if (valid_q && RxReady) valid_d = 1'b0;
        end
    end

    assign RxData    = data_q;
    assign RxValid   = valid_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Overrun   = ovr_q;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter MAX_BITS, default 9: maximum data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16: Tick pulses per bit period, even, legal range 8..32.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth on Rx, minimum 2.
REQ-004 Clk  in  1  sole clock; all logic on posedge Clk.
REQ-005 Rst_n  in  1  reset, synchronous, active-low.
REQ-006 RxEn  in  1  receiver enable.
REQ-007 Rx  in  1  asynchronous serial line; idles high.
REQ-008 Tick  in  1  single-Clk-cycle baud enable strobe at OVERSAMPLE x baud; not a clock.
REQ-009 NBits  in  4  data bits per frame, 5..MAX_BITS.
REQ-010 ParMode  in  2  parity: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 Stop2  in  1  0 = one stop bit, 1 = two stop bits.
REQ-012 RxData  out  MAX_BITS  received word, right-justified, unused MSBs zero.
REQ-013 RxValid  out  1  RxData, ParityErr and FrameErr valid; held until accepted.
REQ-014 RxReady  in  1  consumer accept; transfer occurs when RxValid and RxReady are both high.
REQ-015 ParityErr  out  1  parity mismatch for the word held in RxData.
REQ-016 FrameErr  out  1  a stop bit sampled low for the word held in RxData.
REQ-017 Overrun  out  1  one-cycle pulse: a completed frame was dropped.

Function
REQ-018 Rx SHALL pass through SYNC_STAGES flops before use; all sampling uses the synchronised value.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; the tick counter and bit counter advance only on cycles with Tick high.
REQ-020 IDLE->START on a Tick cycle with RxEn high and synchronised Rx low; the tick counter is cleared.
REQ-021 START: after OVERSAMPLE/2 ticks, Rx is sampled; low -> DATA with counter cleared; high -> IDLE (false start, no output).
REQ-022 DATA: each bit is sampled after OVERSAMPLE ticks and shifted in LSB first; after NBits bits go to PARITY if ParMode is 01 or 10, else to STOP.
REQ-023 PARITY: one bit is sampled after OVERSAMPLE ticks; the error is XOR of data bits and the parity bit, inverted for odd; then go to STOP.
REQ-024 STOP: one stop bit (two if Stop2) is sampled, each after OVERSAMPLE ticks; any low sample sets the frame's FrameErr; the frame completes at the mid-point of the last stop bit.
REQ-025 Completion: the frame SHALL load RxData, ParityErr and FrameErr and set RxValid on the next Clk edge; the state then goes to IDLE, or to WAIT_HIGH if FrameErr.
REQ-026 WAIT_HIGH SHALL wait for synchronised Rx high (break handling), then go to IDLE.
REQ-027 NBits, ParMode and Stop2 SHALL be captured at IDLE->START and held constant for the frame.
REQ-028 Out-of-range NBits SHALL saturate: below 5 is used as 5, above MAX_BITS is used as MAX_BITS.
REQ-029 RxValid SHALL clear on the edge after a transfer unless a new frame completes in that same cycle, in which case the new word loads and RxValid stays high.
REQ-030 If a frame completes while RxValid is high and RxReady is low, the new frame is discarded, the old word is kept, and Overrun pulses for one cycle.
REQ-031 RxEn low in any state other than IDLE SHALL abort to IDLE on the next edge; the partial frame is discarded and the outputs are unchanged.

Reset
REQ-032 Rst_n low at a Clk edge SHALL force IDLE, clear all counters, the shift register and the synchroniser (loaded with 1s), and set RxData=0, RxValid=0, ParityErr=0, FrameErr=0, Overrun=0, including mid-frame.

Structure
REQ-033 Package uart_pkg SHALL hold the state enum, the ParMode encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the legal-range constants.
REQ-034 The synchroniser and falling-level detect SHALL be a sub-module uart_rx_sync, parametrised by SYNC_STAGES.

Verification
REQ-035 Defaults, 8N1, byte 0xA5 sent at 16 ticks/bit -> RxData=0x0A5, RxValid=1, ParityErr=0, FrameErr=0; RxReady pulse -> RxValid=0.
REQ-036 8E1, byte 0x07 with parity bit 0 -> ParityErr=1; same byte with parity bit 1 -> ParityErr=0.
REQ-037 Start low for 6 ticks then high -> no RxValid; a following valid 0x3C is received correctly.
REQ-038 Line held low for 20 bit times -> RxData=0, FrameErr=1; no new start is accepted until Rx returns high.
REQ-039 Two back-to-back frames 0x11 then 0x22 with RxReady=0 -> RxData=0x011, Overrun pulses once; with RxReady=1 asserted on the second completion cycle -> RxData=0x022 and no Overrun.
REQ-040 Rst_n low during bit 3 of a frame -> all outputs 0 next edge; the next frame 0x5A decodes correctly; 5O2 with MAX_BITS=9 and NBits=5 -> RxData upper bits zero.
